fod_dcw_decoder: RTL and testbench
==================================

Name: fod_dcw_decoder

Overview:
- Receive-side counterpart of the FOD control-word generator. It consumes the per-edge MMD_DCW / RT_DCW / DTC_DCW stream and reconstructs the effective output frequency control word over a programmable window.
- Sits beside the FOD controller as a calibration and self-check monitor. It reports the averaged FCW estimate (unsigned, 6 integer + 16 fractional bits) and flags out-of-range control words.

Parameters:
- WI, 6, integer bits of FCW_EST
- WF, 16, fractional bits of FCW_EST and of internal phase
- WDTC, 10, DTC_DCW width
- WG, 18, DTC_GAIN_INV width
- GSH, 10, right-shift applied to DTC_DCW*DTC_GAIN_INV to give a Q0.WF phase
- NMAX, 12, maximum WIN_LOG2
- MMD_MIN, 4, lowest legal MMD_DCW

Ports:
- CLK  in  1  clock
- NRST  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse; arms a measurement and clears ERR
- CLR  in  1  synchronous abort to IDLE
- WIN_LOG2  in  4  window = 2^WIN_LOG2 edges; sampled on START; values >NMAX clamp to NMAX
- DTC_GAIN_INV  in  WG  phase per DTC LSB, scaled by 2^(WF+GSH); sampled on START
- VALID  in  1  control-word triple valid this cycle
- MMD_DCW  in  6  divider ratio of the current edge
- RT_DCW  in  1  half-period retime bit (phase weight 0.5)
- DTC_DCW  in  WDTC  DTC code
- FCW_EST  out  WI+WF  averaged FCW, UQ6.16
- EST_VALID  out  1  one-cycle pulse when FCW_EST updates
- BUSY  out  1  high in every state except IDLE
- ERR  out  1  sticky: an accepted MMD_DCW was below MMD_MIN

Behaviour:
- Reset: all outputs 0, FSM IDLE, accumulators 0.
- Per-edge phase: phi = (RT_DCW<<(WF-1)) + ((DTC_DCW*DTC_GAIN_INV)>>GSH), width WF+1 (may exceed 1.0; no wrap).
- FSM states: IDLE, FIRST, ACCUM, CALC, DONE.
  - IDLE: START -> FIRST. Latch window and gain, clear cnt, sum and ERR.
  - FIRST: first VALID stores phi_start. Its MMD is not summed and not range-checked. -> ACCUM.
  - ACCUM: each VALID adds MMD_DCW to sum (width 6+NMAX) and increments cnt. On the VALID where cnt reaches 2^N, store phi_end -> CALC.
  - CALC: num = (sum<<WF) + phi_end - phi_start (signed, width 6+NMAX+WF+2). FCW_EST = (num + 2^(N-1)) >> N, with the rounding term omitted for N=0. Negative results clamp to 0; results above 2^(WI+WF)-1 saturate to that value. -> DONE.
  - DONE: EST_VALID=1 for this cycle. -> IDLE.
- Latency: EST_VALID is asserted exactly 2 cycles after the last accepted VALID.
- FCW_EST holds its value until the next DONE.
- VALID is ignored in IDLE, CALC and DONE.
- START is ignored while BUSY. START and CLR in the same cycle: CLR wins.
- CLR in any state: go to IDLE next cycle; no EST_VALID; FCW_EST and ERR hold.
- NRST asserted mid-measurement: immediate return to the reset state.
- ERR sets on any VALID in ACCUM with MMD_DCW<MMD_MIN. The edge is still summed. ERR clears only on an accepted START or on reset.

Decomposition:
- Shared package fod_pkg holds:
  - WI/WF constants
  - the FSM state enum
  - the phase typedef (WF+1 bits)
  - MMD_MIN
- One natural sub-module, fod_dcw_phase: a combinational/registered DTC+RT-to-phase mapper, reusable by the FOD calibration loops.

Test Plan:
- Integer ratio: WIN_LOG2=4, gain 0, 17 VALIDs with MMD=8, RT=0, DTC=0 -> EST_VALID 2 cycles after the 17th VALID, FCW_EST=0x080000, ERR=0.
- Half ratio: WIN_LOG2=1, first (RT=1), then (MMD 8, RT 0), then (MMD 9, RT 1) -> FCW_EST=0x088000 (8.5).
- DTC fraction: WIN_LOG2=0, DTC_GAIN_INV=0x10000, first (DTC 0), then (MMD 10, DTC 256) -> phi_end=0x4000, FCW_EST=0x0A4000 (10.25).
- Range error: WIN_LOG2=2, one accepted MMD=3 among MMD=8 -> ERR=1 and stays high after DONE. Next START clears ERR.
- Abort: CLR in ACCUM after 5 edges -> BUSY=0 next cycle, no EST_VALID, FCW_EST unchanged. A following START and full window gives a correct result.
- Boundary: WIN_LOG2=15 clamps to 4096 edges of MMD=63 -> FCW_EST=0x3F0000, no overflow. START while BUSY is ignored, and only one EST_VALID is produced.

Source files
------------

// File: rtl/fod_pkg.sv
// Shared definitions for the FOD control-word blocks.
// Holds the fixed-point widths, the decoder FSM state type, the phase type
// (UQ1.WF, wide enough to represent phases at or above 1.0) and the lowest
// legal divider ratio.
package fod_pkg;

    localparam int WI    = 6;                 // integer bits of the FCW estimate
    localparam int WF    = 16;                // fractional bits of FCW and phase
    localparam int WDTC  = 10;                // DTC code width
    localparam int WG    = 18;                // DTC gain-inverse width
    localparam int GSH   = 10;                // shift from DTC*gain to Q0.WF
    localparam int NMAX  = 12;                // largest supported window log2
    localparam int WFCW  = WI + WF;           // FCW estimate width
    localparam int WCNT  = NMAX + 1;          // edge counter, holds 2^NMAX
    localparam int WSUM  = 6 + NMAX;          // MMD accumulator width
    localparam int WNUM  = 6 + NMAX + WF + 2; // signed numerator width

    localparam logic [5:0] MMD_MIN = 6'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_ACCUM = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } fod_state_e;

    typedef logic [WF:0] fod_phase_t;

    // Window sizes above NMAX are limited to NMAX.
    function automatic logic [3:0] clamp_win(input logic [3:0] win_log2);
        logic [3:0] res;
        if (win_log2 > 4'(NMAX)) begin
            res = 4'(NMAX);
        end else begin
            res = win_log2;
        end
        return res;
    endfunction

endpackage

// File: rtl/fod_dcw_phase.sv
// Maps one edge's RT/DTC control words to its output phase, UQ1.WF.
//   rt_dcw  : half-period retime bit, weight 0.5
//   dtc_dcw : DTC code
//   gain    : phase per DTC LSB scaled by 2^(WF+GSH)
//   phi     : (rt_dcw << (WF-1)) + ((dtc_dcw*gain) >> GSH), kept to WF+1 bits
// Purely combinational so the caller chooses where to register it.
module fod_dcw_phase
    import fod_pkg::*;
#(
    parameter int P_WDTC = WDTC,
    parameter int P_WG   = WG,
    parameter int P_GSH  = GSH
) (
    input  logic              rt_dcw,
    input  logic [P_WDTC-1:0] dtc_dcw,
    input  logic [P_WG-1:0]   gain,
    output fod_phase_t        phi
);

    localparam int WPROD = P_WDTC + P_WG;

    logic [WPROD-1:0] prod_s;
    logic [WPROD-1:0] rt_term_s;

    // Product of code and gain at full width, plus the retime half-period term.
    always_comb begin
        prod_s    = {{P_WG{1'b0}}, dtc_dcw} * {{P_WDTC{1'b0}}, gain};
        rt_term_s = {{(WPROD-WF){1'b0}}, rt_dcw, {(WF-1){1'b0}}};
        phi       = fod_phase_t'(rt_term_s + (prod_s >> P_GSH));
    end

endmodule

// File: rtl/fod_dcw_decoder.sv
// Reconstructs the average output FCW from the per-edge MMD/RT/DTC stream.
// After START the first valid edge fixes the starting phase; the next
// 2^N edges have their divider ratios summed and the last one fixes the end
// phase. FCW_EST = (sum*2^WF + phi_end - phi_start) / 2^N, rounded, clamped.
//   CLK, NRST        : clock, asynchronous active-low reset
//   START, CLR       : arm a measurement / abort to idle (CLR has priority)
//   WIN_LOG2         : window log2, clamped to NMAX, latched on START
//   DTC_GAIN_INV     : phase per DTC LSB, latched on START
//   VALID, MMD_DCW, RT_DCW, DTC_DCW : control-word triple
//   FCW_EST          : UQ6.16 estimate, held until the next completed window
//   EST_VALID        : one-cycle pulse when FCW_EST updates
//   BUSY             : measurement in progress
//   ERR              : sticky, an accumulated MMD_DCW was below MMD_MIN
module fod_dcw_decoder
    import fod_pkg::*;
(
    input  logic            CLK,
    input  logic            NRST,
    input  logic            START,
    input  logic            CLR,
    input  logic [3:0]      WIN_LOG2,
    input  logic [WG-1:0]   DTC_GAIN_INV,
    input  logic            VALID,
    input  logic [5:0]      MMD_DCW,
    input  logic            RT_DCW,
    input  logic [WDTC-1:0] DTC_DCW,
    output logic [WFCW-1:0] FCW_EST,
    output logic            EST_VALID,
    output logic            BUSY,
    output logic            ERR
);

    fod_state_e             state_r;
    fod_state_e             state_s;
    logic [3:0]             n_r;
    logic [WG-1:0]          gain_r;
    logic [WCNT-1:0]        cnt_r;
    logic [WSUM-1:0]        sum_r;
    fod_phase_t             phi_start_r;
    fod_phase_t             phi_end_r;
    logic [WFCW-1:0]        fcw_r;
    logic                   est_valid_r;
    logic                   busy_r;
    logic                   err_r;

    fod_phase_t             phi_s;
    logic [WCNT-1:0]        win_s;
    logic [WCNT-1:0]        cnt_inc_s;
    logic                   arm_s;
    logic                   take_first_s;
    logic                   take_edge_s;
    logic                   last_edge_s;
    logic                   publish_s;
    logic signed [WNUM-1:0] num_s;
    logic signed [WNUM-1:0] round_s;
    logic signed [WNUM-1:0] quot_s;
    logic [WFCW-1:0]        fcw_s;

    // The phase mapper always uses the gain latched at START.
    fod_dcw_phase u_phase (
        .rt_dcw  (RT_DCW),
        .dtc_dcw (DTC_DCW),
        .gain    (gain_r),
        .phi     (phi_s)
    );

    // Window length and the counter value the current edge would reach.
    always_comb begin
        win_s       = {{(WCNT-1){1'b0}}, 1'b1} << n_r;
        cnt_inc_s   = cnt_r + {{(WCNT-1){1'b0}}, 1'b1};
        last_edge_s = (cnt_inc_s == win_s);
    end

    // Next-state and datapath strobes; CLR overrides every state.
    always_comb begin
        state_s      = state_r;
        arm_s        = 1'b0;
        take_first_s = 1'b0;
        take_edge_s  = 1'b0;
        publish_s    = 1'b0;
        if (CLR) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        arm_s   = 1'b1;
                        state_s = ST_FIRST;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FIRST: begin
                    if (VALID) begin
                        take_first_s = 1'b1;
                        state_s      = ST_ACCUM;
                    end else begin
                        state_s = ST_FIRST;
                    end
                end
                ST_ACCUM: begin
                    if (VALID) begin
                        take_edge_s = 1'b1;
                        if (last_edge_s) begin
                            state_s = ST_CALC;
                        end else begin
                            state_s = ST_ACCUM;
                        end
                    end else begin
                        state_s = ST_ACCUM;
                    end
                end
                ST_CALC: begin
                    publish_s = 1'b1;
                    state_s   = ST_DONE;
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Average over the window: rounded arithmetic shift, then clamp to UQ6.16.
    always_comb begin
        num_s = $signed({2'b00, sum_r, {WF{1'b0}}})
              + $signed({{(WNUM-WF-1){1'b0}}, phi_end_r})
              - $signed({{(WNUM-WF-1){1'b0}}, phi_start_r});
        if (n_r == 4'd0) begin
            round_s = '0;
        end else begin
            round_s = $signed({{(WNUM-1){1'b0}}, 1'b1} << (n_r - 4'd1));
        end
        quot_s = (num_s + round_s) >>> n_r;
        if (quot_s[WNUM-1] == 1'b1) begin
            fcw_s = '0;
        end else if (quot_s > $signed({{(WNUM-WFCW){1'b0}}, {WFCW{1'b1}}})) begin
            fcw_s = '1;
        end else begin
            fcw_s = quot_s[WFCW-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Measurement datapath and registered outputs.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            n_r         <= 4'd0;
            gain_r      <= '0;
            cnt_r       <= '0;
            sum_r       <= '0;
            phi_start_r <= '0;
            phi_end_r   <= '0;
            fcw_r       <= '0;
            est_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (arm_s) begin
                n_r    <= clamp_win(WIN_LOG2);
                gain_r <= DTC_GAIN_INV;
                cnt_r  <= '0;
                sum_r  <= '0;
            end else if (take_edge_s) begin
                cnt_r <= cnt_inc_s;
                sum_r <= sum_r + {{(WSUM-6){1'b0}}, MMD_DCW};
            end
            if (take_first_s) begin
                phi_start_r <= phi_s;
            end
            if (take_edge_s && last_edge_s) begin
                phi_end_r <= phi_s;
            end
            // An out-of-range edge is still summed; only the flag records it.
            if (arm_s) begin
                err_r <= 1'b0;
            end else if (take_edge_s && (MMD_DCW < MMD_MIN)) begin
                err_r <= 1'b1;
            end
            if (publish_s) begin
                fcw_r <= fcw_s;
            end
            est_valid_r <= publish_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign FCW_EST   = fcw_r;
    assign EST_VALID = est_valid_r;
    assign BUSY      = busy_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_fod_dcw_decoder.sv
// Self-checking bench for fod_dcw_decoder: directed cases plus randomized
// windows scored against an arithmetic model of the averaged FCW.
module tb_fod_dcw_decoder;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        START;
    logic        CLR;
    logic [3:0]  WIN_LOG2;
    logic [17:0] DTC_GAIN_INV;
    logic        VALID;
    logic [5:0]  MMD_DCW;
    logic        RT_DCW;
    logic [9:0]  DTC_DCW;
    logic [21:0] FCW_EST;
    logic        EST_VALID;
    logic        BUSY;
    logic        ERR;

    int errors = 0;
    int checks = 0;
    int mmd_q[$];
    int rt_q[$];
    int dtc_q[$];
    logic [21:0] last_fcw = 22'd0;

    fod_dcw_decoder dut (
        .CLK          (CLK),
        .NRST         (NRST),
        .START        (START),
        .CLR          (CLR),
        .WIN_LOG2     (WIN_LOG2),
        .DTC_GAIN_INV (DTC_GAIN_INV),
        .VALID        (VALID),
        .MMD_DCW      (MMD_DCW),
        .RT_DCW       (RT_DCW),
        .DTC_DCW      (DTC_DCW),
        .FCW_EST      (FCW_EST),
        .EST_VALID    (EST_VALID),
        .BUSY         (BUSY),
        .ERR          (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Phase of one edge in units of 2^-16 of a period, kept to 17 bits.
    function automatic longint phase_of(input int rt, input int dtc, input longint g);
        longint p;
        p = longint'(rt) * 32768 + (longint'(dtc) * g) / 1024;
        return p % 131072;
    endfunction

    function automatic int eff_n(input int w);
        return (w > 12) ? 12 : w;
    endfunction

    // Average ratio over the window: total periods / edge count, rounded half-up.
    function automatic longint model_fcw(input int w, input longint g);
        int     n;
        int     len;
        longint sum;
        longint num;
        longint q;
        n   = eff_n(w);
        len = 1 << n;
        sum = 0;
        for (int i = 1; i <= len; i++) sum += mmd_q[i];
        num = sum * 65536 + phase_of(rt_q[len], dtc_q[len], g) - phase_of(rt_q[0], dtc_q[0], g);
        if (n > 0) num += longint'(1) << (n - 1);
        q = num >>> n;
        if (q < 0) q = 0;
        if (q > 4194303) q = 4194303;
        return q;
    endfunction

    function automatic logic model_err(input int w);
        logic e;
        e = 1'b0;
        for (int i = 1; i <= (1 << eff_n(w)); i++) if (mmd_q[i] < 4) e = 1'b1;
        return e;
    endfunction

    task automatic clear_q();
        mmd_q.delete();
        rt_q.delete();
        dtc_q.delete();
    endtask

    task automatic push_edge(input int m, input int r, input int d);
        mmd_q.push_back(m);
        rt_q.push_back(r);
        dtc_q.push_back(d);
    endtask

    task automatic fill_random(input int w);
        clear_q();
        for (int i = 0; i <= (1 << eff_n(w)); i++) begin
            push_edge(($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 63),
                      $urandom_range(0, 1), $urandom_range(0, 1023));
        end
    endtask

    task automatic drive_edge(input int m, input int r, input int d, input logic v);
        VALID   = v;
        MMD_DCW = 6'(m);
        RT_DCW  = 1'(r);
        DTC_DCW = 10'(d);
    endtask

    task automatic start_meas(input int w, input logic [17:0] g);
        START        = 1'b1;
        WIN_LOG2     = 4'(w);
        DTC_GAIN_INV = g;
        @(negedge CLK);
        START        = 1'b0;
        WIN_LOG2     = 4'($urandom_range(0, 15));
        DTC_GAIN_INV = 18'($urandom);
    endtask

    // Sends queue entries first..last with random idle gaps; at index nudge
    // a START with a different window is raised while the block is busy.
    task automatic feed(input int first, input int last, input int max_gap, input int nudge);
        int gap;
        for (int i = first; i <= last; i++) begin
            gap = $urandom_range(0, max_gap);
            repeat (gap) begin
                drive_edge($urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 1023), 1'b0);
                @(negedge CLK);
            end
            drive_edge(mmd_q[i], rt_q[i], dtc_q[i], 1'b1);
            if (i == nudge) begin
                START    = 1'b1;
                WIN_LOG2 = 4'd0;
            end
            @(negedge CLK);
            START = 1'b0;
        end
    endtask

    // Watches four cycles after the last edge while VALID garbage is offered.
    task automatic finish_meas(input string tag, input logic [21:0] exp_fcw, input logic exp_err);
        int          pulses;
        int          at;
        logic [21:0] seen;
        pulses = 0;
        at     = -1;
        seen   = 22'd0;
        for (int k = 0; k < 4; k++) begin
            if (EST_VALID === 1'b1) begin
                pulses++;
                at   = k;
                seen = FCW_EST;
            end
            drive_edge($urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 1023), (k < 3));
            @(negedge CLK);
        end
        VALID = 1'b0;
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_latency"}, 64'(at), 64'd1);
        check({tag, "_fcw"}, 64'(seen), 64'(exp_fcw));
        check({tag, "_hold"}, 64'(FCW_EST), 64'(exp_fcw));
        check({tag, "_err"}, 64'(ERR), 64'(exp_err));
        check({tag, "_busy"}, 64'(BUSY), 64'd0);
        last_fcw = exp_fcw;
    endtask

    initial begin
        int          w;
        int          pulses;
        logic [17:0] g;

        NRST = 1'b0; START = 1'b0; CLR = 1'b0; WIN_LOG2 = 4'd0; DTC_GAIN_INV = 18'd0;
        drive_edge(0, 0, 0, 1'b0);
        repeat (3) @(negedge CLK);
        check("rst_fcw", 64'(FCW_EST), 64'd0);
        check("rst_est", 64'(EST_VALID), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        NRST = 1'b1;
        @(negedge CLK);

        // Integer ratio 8 over 16 edges.
        clear_q();
        for (int i = 0; i < 17; i++) push_edge(8, 0, 0);
        start_meas(4, 18'd0);
        check("busy_after_start", 64'(BUSY), 64'd1);
        feed(0, 16, 0, -1);
        finish_meas("integer", 22'h080000, 1'b0);

        // Ratio 8.5 carried by the retime bit.
        clear_q();
        push_edge(8, 1, 0); push_edge(8, 0, 0); push_edge(9, 1, 0);
        start_meas(1, 18'd0);
        feed(0, 2, 1, -1);
        finish_meas("half", 22'h088000, 1'b0);

        // Quarter period from the DTC.
        clear_q();
        push_edge(5, 0, 0); push_edge(10, 0, 256);
        start_meas(0, 18'h10000);
        feed(0, 1, 2, -1);
        finish_meas("dtc", 22'h0A4000, 1'b0);

        // One out-of-range ratio inside the window: flagged and still summed.
        clear_q();
        push_edge(8, 0, 0); push_edge(8, 0, 0); push_edge(3, 0, 0); push_edge(8, 0, 0); push_edge(8, 0, 0);
        start_meas(2, 18'd0);
        feed(0, 4, 1, -1);
        finish_meas("range", 22'h06C000, 1'b1);
        repeat (3) @(negedge CLK);
        check("err_sticky", 64'(ERR), 64'd1);

        // Abort after five accumulated edges.
        clear_q();
        for (int i = 0; i < 9; i++) push_edge($urandom_range(4, 63), $urandom_range(0, 1), $urandom_range(0, 1023));
        g = 18'($urandom);
        start_meas(3, g);
        check("err_cleared", 64'(ERR), 64'd0);
        feed(0, 5, 1, -1);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("abort_busy", 64'(BUSY), 64'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (EST_VALID === 1'b1) pulses++;
            @(negedge CLK);
        end
        check("abort_no_est", 64'(pulses), 64'd0);
        check("abort_fcw_hold", 64'(FCW_EST), 64'(last_fcw));
        START = 1'b1; CLR = 1'b1;
        @(negedge CLK);
        START = 1'b0; CLR = 1'b0;
        check("clr_beats_start", 64'(BUSY), 64'd0);
        fill_random(3);
        g = 18'($urandom);
        start_meas(3, g);
        feed(0, 8, 2, -1);
        finish_meas("after_abort", 22'(model_fcw(3, longint'(g))), model_err(3));

        // Random windows against the model.
        for (int r = 0; r < 8; r++) begin
            w = $urandom_range(0, 5);
            g = 18'($urandom);
            fill_random(w);
            start_meas(w, g);
            feed(0, 1 << w, 2, -1);
            finish_meas($sformatf("rand%0d", r), 22'(model_fcw(w, longint'(g))), model_err(w));
        end

        // Result above 63.99 saturates.
        clear_q();
        push_edge(10, 0, 0); push_edge(63, 1, 400);
        start_meas(0, 18'h20000);
        feed(0, 1, 0, -1);
        finish_meas("saturate", 22'h3FFFFF, 1'b0);

        // Negative numerator clamps to zero.
        clear_q();
        push_edge(10, 1, 400); push_edge(0, 0, 0);
        start_meas(0, 18'h20000);
        feed(0, 1, 0, -1);
        finish_meas("clamp_zero", 22'h000000, 1'b1);

        // Asynchronous reset in the middle of a window.
        fill_random(3);
        start_meas(3, 18'($urandom));
        feed(0, 3, 1, -1);
        #2 NRST = 1'b0;
        #1;
        check("midrst_fcw", 64'(FCW_EST), 64'd0);
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_err", 64'(ERR), 64'd0);
        check("midrst_est", 64'(EST_VALID), 64'd0);
        @(negedge CLK);
        NRST = 1'b1;
        @(negedge CLK);
        last_fcw = 22'd0;

        // WIN_LOG2=15 clamps to 4096 edges; a START mid-window is ignored.
        clear_q();
        for (int i = 0; i < 4097; i++) push_edge(63, 0, 0);
        start_meas(15, 18'($urandom));
        feed(0, 4096, 0, 100);
        finish_meas("boundary", 22'h3F0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
